ram_program_loader: RTL and testbench
=====================================

Name: ram_program_loader

Overview:
- Sequential boot loader sitting directly upstream of the 16x8 program RAM (ports clk, we, oe, address, data_in, data_out).
- Accepts a byte stream over a valid/ready handshake and writes bytes to RAM addresses 0..DEPTH-1.
- Checks a trailing checksum byte, then reads the whole RAM back to verify it.
- Holds the CPU halted until a verified image is resident.

Parameters:
- ADDR_WIDTH, 4, RAM address width.
- DATA_WIDTH, 8, byte width of stream and RAM.
- DEPTH, 16, bytes per image; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load. Honoured only in IDLE, DONE or ERROR.
- in_valid  input  1  stream byte valid.
- in_data  input  DATA_WIDTH  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- ram_we  output  1  drives RAM we.
- ram_oe  output  1  drives RAM oe.
- ram_address  output  ADDR_WIDTH  drives RAM address.
- ram_wdata  output  DATA_WIDTH  drives RAM data_in.
- ram_rdata  input  DATA_WIDTH  from RAM data_out; registered read, valid the cycle after oe and address are presented.
- byte_count  output  ADDR_WIDTH+1  image bytes accepted in the current load.
- cpu_hold  output  1  high keeps the CPU halted.
- done  output  1  verified image is resident.
- error  output  1  checksum or readback mismatch.

Behaviour:
- Reset (synchronous, wins over everything):
  - state=IDLE.
  - cpu_hold=1.
  - in_ready, ram_we, ram_oe, done, error = 0.
  - ram_address, ram_wdata, byte_count, sum = 0.
  - Reset during any state aborts at that edge. Partially written RAM contents are left as-is.
- All outputs are registered except in_ready, which is decoded from state.
- States: IDLE, LOAD, CHECK, VERIFY_RD, VERIFY_CMP, DONE, ERROR.
- IDLE:
  - in_ready=0.
  - start goes to LOAD and clears byte_count, sum, done and error. cpu_hold=1.
- LOAD:
  - in_ready=1.
  - A transfer is in_valid && in_ready at a rising edge.
  - Byte accepted at edge N: ram_we=1, ram_address=byte_count, ram_wdata=in_data for exactly the cycle after edge N. RAM captures at edge N+1.
  - Back-to-back transfers allowed, one byte per cycle.
  - sum = (sum + in_data) mod 2**DATA_WIDTH. byte_count increments.
  - Acceptance of byte DEPTH-1 moves to CHECK (byte_count=DEPTH).
  - in_valid with no transfer has no effect.
- CHECK:
  - in_ready=1. The next transfer is the checksum; it is not written to RAM.
  - Checksum != sum goes to ERROR.
  - Checksum == sum goes to VERIFY_RD with readback address 0 and rsum=0.
- VERIFY_RD:
  - in_ready=0. Drive ram_oe=1, ram_address=raddr for one cycle, then go to VERIFY_CMP.
- VERIFY_CMP:
  - ram_oe=0. Sample ram_rdata and set rsum += ram_rdata.
  - If raddr=DEPTH-1: compare rsum (including this byte) with sum. Match goes to DONE; mismatch goes to ERROR.
  - Otherwise raddr+1 (no wrap past DEPTH-1) and return to VERIFY_RD.
  - Readback is 2 cycles per address, 2*DEPTH cycles in total.
- DONE: done=1, cpu_hold=0. Held until reset or start.
- ERROR: error=1, cpu_hold=1. Held until reset or start.
- start while in LOAD, CHECK or VERIFY_* is ignored.
- Invariants:
  - ram_we and ram_oe are never high in the same cycle.
  - ram_we is never high outside the cycle after a LOAD transfer.
  - done and error are mutually exclusive.
  - cpu_hold=0 only in DONE.
- Latency, start to done with in_valid held high: 1 + DEPTH + 1 + 2*DEPTH + 1 cycles (51 for DEPTH=16).

Test Plan:
- Reset, then stream 0x00..0x0F and checksum 0x78 back-to-back → 16 write pulses to addresses 0..15 with data = address; readback phase; done=1, cpu_hold=0, error=0, byte_count=16; RAM[3]=0x03, RAM[10]=0x0A.
- Stream 0xAB at every address, checksum 0xB0 ((16*0xAB) mod 256) → done=1; a corrupt checksum 0xB1 instead → error=1, done=0, cpu_hold=1, no readback oe pulses.
- Throttled stream (in_valid toggling every other cycle) → ram_we pulses only the cycle after each accepted byte; addresses strictly 0..15; result identical to scenario 1.
- Readback fault: bench RAM model flips bit 0 at address 0x7 on read → error=1 after the 32-cycle readback; done=0.
- Assert reset after 5 bytes accepted → next cycle: IDLE, cpu_hold=1, ram_we=0, byte_count=0. A subsequent start and full load of image 1 → done=1.
- start pulsed mid-LOAD → ignored, byte_count continues. start in DONE → done clears, cpu_hold=1, fresh load begins at address 0.

Source files
------------

// File: rtl/ram_program_loader.sv
// Boot loader: streams an image into the program RAM, checks the trailing
// checksum, reads the RAM back to confirm it, then releases the CPU.
module ram_program_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH:0]   byte_count,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_VERIFY_RD, S_VERIFY_CMP, S_DONE, S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH:0]   LAST_CNT  = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  function automatic logic [DATA_WIDTH-1:0] sum_wrap(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    return a + b;
  endfunction

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] rsum_q, rsum_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] rsum_next;

  assign in_ready  = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign xfer      = in_valid && in_ready;
  assign rsum_next = sum_wrap(rsum_q, ram_rdata);

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    oe_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    raddr_d = raddr_q;
    rsum_d  = rsum_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          sum_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_WIDTH-1:0];
          wdata_d = in_data;
          sum_d   = sum_wrap(sum_q, in_data);
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          if (in_data != sum_q) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            hold_d  = 1'b1;
          end else begin
            // oe is registered, so it is raised on entry to VERIFY_RD
            state_d = S_VERIFY_RD;
            raddr_d = '0;
            rsum_d  = '0;
            oe_d    = 1'b1;
            addr_d  = '0;
          end
        end
      end
      S_VERIFY_RD: begin
        state_d = S_VERIFY_CMP;
      end
      S_VERIFY_CMP: begin
        rsum_d = rsum_next;
        if (raddr_q == LAST_ADDR) begin
          if (rsum_next == sum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            hold_d  = 1'b1;
          end
        end else begin
          state_d = S_VERIFY_RD;
          raddr_d = raddr_q + 1'b1;
          addr_d  = raddr_q + 1'b1;
          oe_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      raddr_q <= '0;
      rsum_q  <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      raddr_q <= raddr_d;
      rsum_q  <= rsum_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ram_we      = we_q;
  assign ram_oe      = oe_q;
  assign ram_address = addr_q;
  assign ram_wdata   = wdata_q;
  assign byte_count  = cnt_q;
  assign cpu_hold    = hold_q;
  assign done        = done_q;
  assign error       = err_q;

  a_we_oe_excl: assert property (@(posedge clk) disable iff (reset) !(ram_we && ram_oe));
  a_done_err_excl: assert property (@(posedge clk) disable iff (reset) !(done && error));

endmodule

// File: tb/tb_ram_program_loader.sv
// Randomised scoreboard bench for ram_program_loader with a behavioural RAM.
module tb_ram_program_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, ram_we, ram_oe, cpu_hold, done, error;
  logic [3:0] ram_address;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic [4:0] byte_count;

  always #5 clk = ~clk;

  ram_program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .byte_count(byte_count), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  // 16x8 program RAM with registered read and an optional bit-0 fault at 0x7
  logic [7:0] mem [16];
  bit         fault_en = 1'b0;
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_address] <= ram_wdata;
    if (ram_oe) ram_rdata <= mem[ram_address] ^ {7'd0, (fault_en && ram_address == 4'd7)};
  end

  typedef logic [7:0] img_t [16];
  typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;
  typedef struct packed { logic d; logic e; logic [5:0] oe; } out_t;

  wr_t  exp_wr [$];
  out_t exp_out[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wr_ptr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); in_valid = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Present one byte; returns right after the edge that accepts it
  task automatic send(input logic [7:0] b, input bit is_ck, input bit with_start);
    int guard = 0;
    wr_t w;
    @(negedge clk);
    in_valid = 1'b1; in_data = b; start = with_start;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
    if (!is_ck) begin
      w.a = wr_ptr[3:0]; w.d = b;
      exp_wr.push_back(w);
      wr_ptr++;
    end
    @(posedge clk);
  endtask

  task automatic run_load(input img_t img, input logic [7:0] ck, input int gap_mode,
                          input int start_at, input bit do_start);
    int   s = 0;
    int   rs = 0;
    int   gap;
    int   guard = 0;
    out_t o;
    if (do_start) pulse_start();
    wr_ptr = 0;
    for (int i = 0; i < 16; i++) begin
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      if (i > 0) repeat (gap) begin @(negedge clk); in_valid = 1'b0; start = 1'b0; end
      send(img[i], 1'b0, (i == start_at));
      s += int'(img[i]);
      rs += int'(img[i] ^ ((fault_en && i == 7) ? 8'h01 : 8'h00));
    end
    if (ck != s[7:0]) begin o.d = 1'b0; o.e = 1'b1; o.oe = 6'd0; end
    else if (rs[7:0] == s[7:0]) begin o.d = 1'b1; o.e = 1'b0; o.oe = 6'd16; end
    else begin o.d = 1'b0; o.e = 1'b1; o.oe = 6'd16; end
    exp_out.push_back(o);
    send(ck, 1'b1, 1'b0);
    @(negedge clk); in_valid = 1'b0; start = 1'b0;
    while (exp_out.size() != 0 && guard < 300) begin @(posedge clk); guard++; end
    if (exp_out.size() != 0) begin
      check("finish_timeout", 32'd0, 32'd1);
      exp_out.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: pops expected writes and results as the DUT presents them
  initial begin
    bit   prev_fin = 1'b0;
    bit   fin;
    int   oe_cnt = 0;
    wr_t  w;
    out_t o;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        prev_fin = 1'b0; oe_cnt = 0;
      end else begin
        if (start) oe_cnt = 0;
        if (ram_oe) oe_cnt++;
        if (ram_we) begin
          if (exp_wr.size() == 0) check("unexpected_we", 32'd1, 32'd0);
          else begin
            w = exp_wr.pop_front();
            check("wr_addr", 32'(ram_address), 32'(w.a));
            check("wr_data", 32'(ram_wdata), 32'(w.d));
          end
        end
        check("we_oe_excl", 32'(ram_we && ram_oe), 32'd0);
        check("done_err_excl", 32'(done && error), 32'd0);
        check("hold_vs_done", 32'(cpu_hold), 32'(!done));
        fin = done || error;
        if (fin && !prev_fin) begin
          if (exp_out.size() == 0) check("unexpected_finish", 32'd1, 32'd0);
          else begin
            o = exp_out.pop_front();
            check("res_done", 32'(done), 32'(o.d));
            check("res_error", 32'(error), 32'(o.e));
            check("res_cpu_hold", 32'(cpu_hold), 32'(!o.d));
            check("res_byte_count", 32'(byte_count), 32'd16);
            check("res_oe_pulses", 32'(oe_cnt), 32'(o.oe));
          end
        end
        prev_fin = fin;
      end
    end
  end

  initial begin
    img_t img1, imgab, imgr;
    int   s;
    logic [7:0] ck;

    for (int i = 0; i < 16; i++) begin img1[i] = 8'(i); imgab[i] = 8'hAB; end

    repeat (3) @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_oe", 32'(ram_oe), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_byte_count", 32'(byte_count), 32'd0);
    check("rst_address", 32'(ram_address), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Counting image, back-to-back
    run_load(img1, 8'h78, 0, -1, 1'b1);
    check("ram3", 32'(mem[3]), 32'h03);
    check("ram10", 32'(mem[10]), 32'h0A);

    // Constant image: good then corrupt checksum
    run_load(imgab, 8'hB0, 0, -1, 1'b1);
    run_load(imgab, 8'hB1, 0, -1, 1'b1);

    // Throttled counting image
    run_load(img1, 8'h78, 1, -1, 1'b1);

    // Readback fault at address 7
    fault_en = 1'b1;
    run_load(img1, 8'h78, 0, -1, 1'b1);
    fault_en = 1'b0;

    // Reset after 5 accepted bytes
    pulse_start();
    wr_ptr = 0;
    for (int i = 0; i < 5; i++) send(img1[i], 1'b0, 1'b0);
    @(negedge clk); in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    check("abort_cpu_hold", 32'(cpu_hold), 32'd1);
    check("abort_we", 32'(ram_we), 32'd0);
    check("abort_byte_count", 32'(byte_count), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); reset = 1'b0;
    run_load(img1, 8'h78, 0, -1, 1'b1);

    // start mid-LOAD is ignored
    for (int i = 0; i < 16; i++) imgr[i] = 8'($urandom);
    s = 0;
    for (int i = 0; i < 16; i++) s += int'(imgr[i]);
    run_load(imgr, s[7:0], 0, 6, 1'b1);

    // start in DONE restarts cleanly
    pulse_start();
    check("restart_done", 32'(done), 32'd0);
    check("restart_cpu_hold", 32'(cpu_hold), 32'd1);
    check("restart_byte_count", 32'(byte_count), 32'd0);
    run_load(img1, 8'h78, 0, -1, 1'b0);

    // Random images, random throttling, occasional bad checksum
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 16; i++) imgr[i] = 8'($urandom);
      s = 0;
      for (int i = 0; i < 16; i++) s += int'(imgr[i]);
      ck = s[7:0];
      if ($urandom_range(0, 3) == 0) ck = ck ^ 8'(1 << $urandom_range(0, 7));
      run_load(imgr, ck, 2, -1, 1'b1);
    end

    repeat (4) @(posedge clk); #1;
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("out_queue_empty", 32'(exp_out.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
